// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent power-of-two clock dividers with per-channel enable/mode/shift.
// Config lands in a shadow register and is committed only at a period boundary.
module mccd_channel #(
  parameter int BASE_HALF = 50000000,
  parameter int SHIFT_W   = 3,
  parameter int CNT_W     = 26
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               wr,
  input  logic [SHIFT_W+1:0] wr_cfg,   // {en, mode, shift}
  output logic               sclk,
  output logic               tick,
  output logic               pending
);
  localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_HALF);

  logic [CNT_W-1:0]   count, limit;
  logic               act_en, act_mode, term;
  logic [SHIFT_W-1:0] act_shift;
  logic [SHIFT_W+1:0] shadow;

  // Shifts at or beyond CNT_W shift everything out, giving a limit of 0.
  assign limit = BASE >> act_shift;
  assign term  = act_en && (count == limit);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count     <= '0;
      sclk      <= 1'b1;
      tick      <= 1'b0;
      pending   <= 1'b0;
      act_en    <= 1'b0;
      act_mode  <= 1'b0;
      act_shift <= '0;
      shadow    <= '0;
    end else begin
      tick <= 1'b0;
      if (act_en) begin
        if (term) begin
          count <= '0;
          tick  <= 1'b1;
          if (!act_mode) sclk <= ~sclk;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
      // Boundary commit: the finishing half-period used the old mode above.
      if (pending && term) begin
        {act_en, act_mode, act_shift} <= shadow;
        count   <= '0;
        pending <= 1'b0;
      end
      // wr only arrives with pending=0, so a same-edge terminal does not commit it.
      if (wr) begin
        shadow <= wr_cfg;
        if (!act_en) begin
          {act_en, act_mode, act_shift} <= wr_cfg;
          count <= '0;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end
endmodule

module multi_channel_clock_divider #(
  parameter int  NUM_CH    = 2,
  parameter int  BASE_HALF = 50000000,
  parameter int  SHIFT_W   = 3,
  localparam int CNT_W     = $clog2(BASE_HALF + 1),
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic               cfg_en,
  input  logic               cfg_mode,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic [NUM_CH-1:0]  sclk,
  output logic [NUM_CH-1:0]  tick,
  output logic [NUM_CH-1:0]  pending
);
  // Out-of-range channel indices are always ready and simply dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      if (cfg_ch == CH_W'(c)) cfg_ready = ~pending[c];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr;
    assign wr = cfg_valid && cfg_ready && (cfg_ch == CH_W'(c));
    mccd_channel #(
      .BASE_HALF(BASE_HALF),
      .SHIFT_W  (SHIFT_W),
      .CNT_W    (CNT_W)
    ) u_ch (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .wr     (wr),
      .wr_cfg ({cfg_en, cfg_mode, cfg_shift}),
      .sclk   (sclk[c]),
      .tick   (tick[c]),
      .pending(pending[c])
    );
  end
endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Randomised scoreboard bench: a cycle-level reference model predicts outputs,
// a negedge monitor pops predictions and compares them with the DUT.
module tb_multi_channel_clock_divider;
  localparam int NCH = 3, BH = 7, SW = 3, CHW = 2;

  logic           CLK = 1'b0, RST_N;
  logic           cfg_valid, cfg_ready, cfg_en, cfg_mode;
  logic [CHW-1:0] cfg_ch;
  logic [SW-1:0]  cfg_shift;
  logic [NCH-1:0] sclk, tick, pending;

  always #5 CLK = ~CLK;

  multi_channel_clock_divider #(.NUM_CH(NCH), .BASE_HALF(BH), .SHIFT_W(SW)) dut (
    .CLK(CLK), .RST_N(RST_N), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
    .sclk(sclk), .tick(tick), .pending(pending));

  typedef struct { logic [NCH-1:0] sclk, tick, pend; logic rdy; } exp_t;
  exp_t q[$];
  int n_run = 0, n_fail = 0;

  // Reference model state (active config, shadow config, position in half-period).
  int m_en[NCH], m_mode[NCH], m_shift[NCH], s_en[NCH], s_mode[NCH], s_shift[NCH], m_cnt[NCH];
  bit m_sclk[NCH], m_tick[NCH], m_pend[NCH];
  bit h_v; int h_ch, h_en, h_mode, h_shift;

  function automatic int half_len(int sh);
    return BH / (1 << sh) + 1;
  endfunction

  task automatic chk(string nm, logic [NCH-1:0] act, logic [NCH-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic reset_model();
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_mode[c] = 0; m_shift[c] = 0; s_en[c] = 0; s_mode[c] = 0; s_shift[c] = 0;
      m_cnt[c] = 0; m_sclk[c] = 1; m_tick[c] = 0; m_pend[c] = 0;
    end
    h_v = 0; h_ch = 0; h_en = 0; h_mode = 0; h_shift = 0;
  endtask

  // One clock edge: m_cnt counts elapsed cycles in the half-period; a boundary
  // is reached when the half-period length has been used up.
  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit xfer, bnd, was_en;
      xfer   = h_v && (h_ch == c) && !m_pend[c];
      was_en = m_en[c] != 0;
      bnd    = was_en && (m_cnt[c] + 1 == half_len(m_shift[c]));
      m_tick[c] = 0;
      if (was_en) begin
        m_cnt[c]++;
        if (bnd) begin
          m_cnt[c] = 0; m_tick[c] = 1;
          if (m_mode[c] == 0) m_sclk[c] = !m_sclk[c];
        end
      end
      if (m_pend[c] && bnd) begin
        m_en[c] = s_en[c]; m_mode[c] = s_mode[c]; m_shift[c] = s_shift[c];
        m_cnt[c] = 0; m_pend[c] = 0;
      end
      if (xfer) begin
        s_en[c] = h_en; s_mode[c] = h_mode; s_shift[c] = h_shift;
        if (!was_en) begin
          m_en[c] = h_en; m_mode[c] = h_mode; m_shift[c] = h_shift; m_cnt[c] = 0;
        end else m_pend[c] = 1;
      end
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    for (int c = 0; c < NCH; c++) begin
      e.sclk[c] = m_sclk[c]; e.tick[c] = m_tick[c]; e.pend[c] = m_pend[c];
    end
    e.rdy = (h_ch >= NCH) ? 1'b1 : !m_pend[h_ch];
    return e;
  endfunction

  task automatic step(bit v, int ch, int en, int mode, int sh);
    @(posedge CLK);
    model_edge();
    #2;
    cfg_valid = v; cfg_ch = CHW'(ch); cfg_en = en[0]; cfg_mode = mode[0]; cfg_shift = SW'(sh);
    h_v = v; h_ch = ch; h_en = en & 1; h_mode = mode & 1; h_shift = sh;
    q.push_back(predict());
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sclk", sclk, e.sclk);
      chk("tick", tick, e.tick);
      chk("pending", pending, e.pend);
      chk("cfg_ready", {{(NCH-1){1'b0}}, cfg_ready}, {{(NCH-1){1'b0}}, e.rdy});
    end
  end

  initial begin
    RST_N = 1'b0; cfg_valid = 0; cfg_ch = '0; cfg_en = 0; cfg_mode = 0; cfg_shift = '0;
    reset_model();
    #8;
    chk("rst_sclk", sclk, '1);
    chk("rst_tick", tick, '0);
    chk("rst_pending", pending, '0);
    #4 RST_N = 1'b1;

    // ch0 free-running at shift 0, then a pending shift change and a stalled rewrite
    step(1, 0, 1, 0, 0); idle(20);
    step(1, 0, 1, 0, 2); step(1, 0, 1, 0, 3); step(1, 0, 1, 0, 3); idle(14);
    // ch1 at L=0 and a stalled second write
    step(1, 1, 1, 0, 3); idle(3); step(1, 1, 1, 0, 3); step(1, 1, 1, 0, 3);
    step(1, 1, 1, 0, 0); idle(6);
    // tick-only mode, out-of-range channel, then disable/re-enable ch0
    step(1, 0, 1, 1, 0); idle(20); step(1, 3, 1, 0, 0); idle(4);
    step(1, 0, 0, 0, 0); idle(20); step(1, 0, 1, 0, 1); idle(10);

    repeat (3000)
      step($urandom_range(3) == 0, $urandom_range(3), $urandom_range(4) != 0,
           $urandom_range(1), $urandom_range(7));

    // Asynchronous reset mid-period, checked before the next edge
    @(negedge CLK); #1;
    @(posedge CLK); #3;
    cfg_valid = 0; RST_N = 1'b0;
    #1;
    chk("async_rst_sclk", sclk, '1);
    chk("async_rst_tick", tick, '0);
    chk("async_rst_pending", pending, '0);
    reset_model();
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1 RST_N = 1'b1;
    idle(12);

    repeat (1000)
      step($urandom_range(2) == 0, $urandom_range(3), $urandom_range(3) != 0,
           $urandom_range(1), $urandom_range(7));

    @(negedge CLK); #1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
